// File: rtl/dwc_pkg.sv
// rtl/dwc_pkg.sv - shared types, constants and helpers for detect_window_counter
// Contents: state_e FSM encoding, default widths, CNT_MAX, WIN_MIN, sat_inc().
package dwc_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};
  localparam int                   WIN_MIN = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Saturating add of a single-bit increment; callers pass their own ceiling so
  // the helper works for any count width up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic        inc,
                                          input logic [31:0] max);
    if (inc && (count < max)) begin
      return count + 32'd1;
    end
    return count;
  endfunction

endpackage

// File: rtl/detect_window_counter_if.sv
// rtl/detect_window_counter_if.sv - result valid/ready channel of detect_window_counter
// Signals: result_count, result_alarm, result_valid (producer -> consumer),
//          result_ready (consumer -> producer).
// Modports: master = result producer, slave = result consumer.
interface detect_window_counter_if
  import dwc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [CNT_W-1:0] result_count;
  logic             result_alarm;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output result_count,
    output result_alarm,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result_count,
    input  result_alarm,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/dwc_result_reg.sv
// rtl/dwc_result_reg.sv - single-entry result holding register with overrun tracking
// Ports: clk, reset (async, active-high), capture_i (window end strobe),
//        final_i (window count), threshold_i, clear_overrun_i, overrun_o,
//        res (master side of the result channel).
module dwc_result_reg
  import dwc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_i,
  input  logic [CNT_W-1:0]        final_i,
  input  logic [CNT_W-1:0]        threshold_i,
  input  logic                    clear_overrun_i,
  output logic                    overrun_o,
  detect_window_counter_if.master res
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  // A capture only fits if the slot is empty or is being emptied on this edge.
  assign drop = capture_i && valid_q && !res.result_ready;

  always_comb begin
    count_d   = count_q;
    alarm_d   = alarm_q;
    valid_d   = valid_q;
    if (capture_i && !drop) begin
      count_d = final_i;
      alarm_d = (final_i >= threshold_i);
      valid_d = 1'b1;
    end else if (valid_q && res.result_ready) begin
      valid_d = 1'b0;
    end
    // Set dominates clear so a drop on the clearing edge is never lost.
    overrun_d = drop | (overrun_q & ~clear_overrun_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      alarm_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      alarm_q   <= alarm_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign res.result_count = count_q;
  assign res.result_alarm = alarm_q;
  assign res.result_valid = valid_q;
  assign overrun_o        = overrun_q;

endmodule

// File: rtl/detect_window_counter.sv
// rtl/detect_window_counter.sv - counts detect pulses per programmable window
// Ports: clk, reset (async, active-high), enable, detected, win_len, threshold,
//        clear_overrun, overrun (sticky drop flag), res (result channel master).
module detect_window_counter
  import dwc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    detected,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [CNT_W-1:0]        threshold,
  input  logic                    clear_overrun,
  output logic                    overrun,
  detect_window_counter_if.master res
);

  localparam logic [CNT_W-1:0] CNT_LIM = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_len_eff;
  logic [CNT_W-1:0] fin_cnt;
  logic             win_end;

  assign win_len_eff = (win_len == '0) ? WIN_W'(WIN_MIN) : win_len;
  assign fin_cnt     = CNT_W'(sat_inc(32'(ev_cnt_q), detected, 32'(CNT_LIM)));
  // A cycle with enable low is an abort, never a completed window.
  assign win_end     = (state_q == RUN) && enable &&
                       (win_cnt_q == (win_len_q - WIN_W'(1)));

  always_comb begin
    state_d   = state_q;
    ev_cnt_d  = ev_cnt_q;
    win_cnt_d = win_cnt_q;
    win_len_d = win_len_q;
    case (state_q)
      IDLE: begin
        ev_cnt_d  = '0;
        win_cnt_d = '0;
        if (enable) begin
          state_d   = RUN;
          win_len_d = win_len_eff;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d   = IDLE;
          ev_cnt_d  = '0;
          win_cnt_d = '0;
        end else if (win_end) begin
          // Back-to-back windows: restart counters and reload length at once.
          ev_cnt_d  = '0;
          win_cnt_d = '0;
          win_len_d = win_len_eff;
        end else begin
          ev_cnt_d  = fin_cnt;
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ev_cnt_q  <= '0;
      win_cnt_q <= '0;
      win_len_q <= WIN_W'(WIN_MIN);
    end else begin
      state_q   <= state_d;
      ev_cnt_q  <= ev_cnt_d;
      win_cnt_q <= win_cnt_d;
      win_len_q <= win_len_d;
    end
  end

  dwc_result_reg #(
    .CNT_W (CNT_W)
  ) u_result_reg (
    .clk             (clk),
    .reset           (reset),
    .capture_i       (win_end),
    .final_i         (fin_cnt),
    .threshold_i     (threshold),
    .clear_overrun_i (clear_overrun),
    .overrun_o       (overrun),
    .res             (res)
  );

endmodule

// File: doc/detect_window_counter.md
Name: detect_window_counter

Overview:
Downstream consumer of the overlapping sequence detector's single-cycle `detected` pulse. It counts detection events over a programmable window of clock cycles. At each window end it publishes the count, plus a threshold-alarm flag, through a single-entry valid/ready result register. Typical use is pattern-rate monitoring on a serial bit stream.

Parameters:
CNT_W, 8, width of event count and threshold; count saturates at 2^CNT_W-1
WIN_W, 16, width of window-length input and window cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  level; 1 = run windows, 0 = idle
detected  input  1  event pulse from sequence detector, sampled every cycle
win_len  input  WIN_W  window length in cycles; sampled at window start; 0 treated as 1
threshold  input  CNT_W  alarm threshold; sampled at window end
result_count  output  CNT_W  event count of last completed window
result_alarm  output  1  1 when result_count >= threshold at capture
result_valid  output  1  result register holds unconsumed data
result_ready  input  1  consumer accepts result when high with result_valid
overrun  output  1  sticky; a window result was dropped because the register was still full
clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, high): state=IDLE; ev_cnt=0; win_cnt=0; win_len_q=1; result_count=0; result_alarm=0; result_valid=0; overrun=0.
- FSM states:
  - IDLE: counters held at 0. enable=1 moves to RUN at the next edge and loads win_len_q=max(win_len,1). detected is ignored in IDLE, including the transition cycle.
  - RUN: each cycle, detected=1 increments ev_cnt, saturating at 2^CNT_W-1. win_cnt advances by 1 per cycle.
- Window end: the cycle with win_cnt==win_len_q-1.
  - final = sat(ev_cnt+detected).
  - Next edge: ev_cnt=0, win_cnt=0, win_len_q reloaded from win_len (0->1). The next window starts immediately with no gap cycle.
- Capture at window end:
  - If result_valid==0, or result_valid&&result_ready in the same cycle: result_count=final, result_alarm=(final>=threshold), result_valid=1.
  - Otherwise the new result is discarded, overrun=1, and the old result is kept unchanged.
- Handshake:
  - result_valid stays high and result_count/result_alarm stay stable until result_ready is sampled high.
  - result_valid falls on that edge unless a new capture happens on the same edge, in which case it stays 1 with new data.
  - result_ready while result_valid=0 has no effect.
- Latency: result_valid rises on the edge immediately after the last window cycle, i.e. 1 cycle after the final detected sample.
- enable=0 while in RUN: next edge goes to IDLE and the partial window is discarded (ev_cnt, win_cnt cleared). The pending result register and overrun are unaffected, and the handshake continues in IDLE.
- overrun: set by a dropped capture, cleared by clear_overrun. If set and clear happen on the same edge, set wins.
- win_len changes mid-window have no effect until the next window start.
- Reset mid-window or mid-handshake: immediate clear to reset values. No result is emitted for the partial window.

Decomposition:
- Shared package dwc_pkg:
  - state enum (IDLE, RUN), 1-bit encoding.
  - localparams CNT_MAX = {CNT_W{1'b1}} and WIN_MIN = 1.
  - function sat_inc(count, inc) returning the saturating sum.
- One natural sub-module: dwc_result_reg, the single-entry valid/ready holding register with capture/drop/overrun logic. Top level holds the FSM and counters.

Test Plan:
- win_len=4, threshold=2, enable=1, detected=1,0,1,1 in window cycles 0-3, result_ready=1 -> result_valid=1 one cycle after cycle 3; result_count=3, result_alarm=1; valid drops next edge.
- win_len=0 -> each cycle is a window; detected=1,0,1 -> consecutive results 1,0,1, result_valid continuously high with ready=1.
- CNT_W=8, win_len=300, detected held 1 -> result_count=255 (saturated), result_alarm=1 when threshold=255.
- win_len=2, result_ready=0 for two windows -> first result held; second dropped; overrun=1; clear_overrun with a simultaneous third drop keeps overrun=1.
- enable drops after 3 cycles of win_len=8 with 3 events, re-enabled -> no result for the partial window; next full window counts from 0.
- Assert reset mid-window with result_valid=1 -> all outputs 0 asynchronously; after release and enable, first result reflects only post-reset events.
